ha_serial_add_ctrl: RTL and testbench

//   Sequencer that time-multiplexes one external 1-bit half-adder cell (sum=a^b, carry=a&b)
//   to perform WIDTH-bit unsigned addition, LSB first, two half-adder passes per bit.

---
 rtl/ha_serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_ha_serial_add_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_add_ctrl.sv
// rtl/ha_serial_add_ctrl.sv - sequencer driving one external half-adder cell for WIDTH-bit serial addition
module ha_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_s,
    input  logic             ha_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, p_q, p_d, sum_q;
    logic [CW-1:0]     bit_q;
    logic              phase_q, carry_q, carry_d, s1_q, c1_q, cout_q;
    logic              accept, last_step;
    logic [WIDTH-1:0]  a_sh, b_sh;

    // Operand bit selected by the counter; shifting avoids an out-of-range index.
    assign a_sh = a_q >> bit_q;
    assign b_sh = b_q >> bit_q;

    // A start is only honoured when no sum is in flight.
    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_step = (state_q == S_RUN) && phase_q && (bit_q == LAST_BIT);

    // Second pass folds the two partial carries and places the final sum bit.
    assign carry_d = c1_q | ha_c;
    assign p_d     = p_q | (WIDTH'(ha_s) << bit_q);

    assign sum  = sum_q;
    assign cout = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE/DONE accept a start, RUN ends after the last bit's second pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: cell inputs are parked at zero outside RUN so the shared cell stays quiet.
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN: begin
                busy = 1'b1;
                if (phase_q) begin
                    ha_a = s1_q;
                    ha_b = carry_q;
                end else begin
                    ha_a = a_sh[0];
                    ha_b = b_sh[0];
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-phase cell sampling and result commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            p_q     <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            carry_q <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (!phase_q) begin
                s1_q    <= ha_s;
                c1_q    <= ha_c;
                phase_q <= 1'b1;
            end else begin
                p_q     <= p_d;
                carry_q <= carry_d;
                phase_q <= 1'b0;
                if (bit_q == LAST_BIT) begin
                    sum_q  <= p_d;
                    cout_q <= carry_d;
                end else begin
                    bit_q <= bit_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// tb/tb_ha_serial_add_ctrl.sv - directed self-checking bench for ha_serial_add_ctrl
module tb_ha_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] op_a8, op_b8;
    logic       ha_a8, ha_b8, ha_s8, ha_c8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1;
    logic       op_a1, op_b1;
    logic       ha_a1, ha_b1, ha_s1, ha_c1;
    logic       busy1, done1, cout1;
    logic       sum1;

    int n_checks;
    int n_fail;

    assign ha_s8 = ha_a8 ^ ha_b8;
    assign ha_c8 = ha_a8 & ha_b8;
    assign ha_s1 = ha_a1 ^ ha_b1;
    assign ha_c1 = ha_a1 & ha_b1;

    ha_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .ha_a(ha_a8), .ha_b(ha_b8), .ha_s(ha_s8), .ha_c(ha_c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    ha_serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .ha_a(ha_a1), .ha_b(ha_b1), .ha_s(ha_s1), .ha_c(ha_c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_done8(output int n);
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (busy1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, sum8, cout8, ha_a8, ha_b8} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b ha=%b%b required all 0",
                     busy8, done8, sum8, cout8, ha_a8, ha_b8);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1, ha_a1, ha_b1} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b ha=%b%b required all 0",
                     busy1, done1, sum1, cout1, ha_a1, ha_b1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy8, done8, ha_a8, ha_b8} !== 4'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b ha=%b%b required 0",
                     busy8, done8, ha_a8, ha_b8);
        end
    endtask

    task automatic test_basic;
        int n;
        start8 = 1'b1; op_a8 = 8'h35; op_b8 = 8'h4A;
        @(negedge clk);
        start8 = 1'b0; op_a8 = 8'h00; op_b8 = 8'h00;
        n_checks++;
        if ({busy8, ha_a8, ha_b8} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_first_run: got busy=%b ha=%b%b required busy=1 ha=10", busy8, ha_a8, ha_b8);
        end
        wait_done8(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d required 16", n);
        end
        n_checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h7F}) begin
            n_fail++;
            $display("FAIL basic_result: got done=%b cout=%b sum=%h required done=1 cout=0 sum=7f",
                     done8, cout8, sum8);
        end
        n_checks++;
        if ({ha_a8, ha_b8} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_ha_quiet_done: got %b%b required 00", ha_a8, ha_b8);
        end
        @(negedge clk);
        n_checks++;
        if ({done8, busy8, sum8} !== {1'b0, 1'b0, 8'h7F}) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b busy=%b sum=%h required done=0 busy=0 sum=7f",
                     done8, busy8, sum8);
        end
    endtask

    task automatic test_ripple;
        int n;
        start8 = 1'b1; op_a8 = 8'hFF; op_b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL ripple_busy_cycles: got %0d required 16", n);
        end
        n_checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL ripple_result: got done=%b cout=%b sum=%h required done=1 cout=1 sum=00",
                     done8, cout8, sum8);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int n;
        start8 = 1'b1; op_a8 = 8'h0F; op_b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            if (n == 5) begin
                start8 = 1'b1; op_a8 = 8'hAA; op_b8 = 8'h55;
            end else if (n == 6) begin
                start8 = 1'b0; op_a8 = 8'hFF; op_b8 = 8'hFF;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL ignore_busy_cycles: got %0d required 16", n);
        end
        n_checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL ignore_result: got done=%b cout=%b sum=%h required done=1 cout=0 sum=10",
                     done8, cout8, sum8);
        end
        @(negedge clk);
        n_checks++;
        if ({done8, busy8} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_no_second_op: got done=%b busy=%b required 00", done8, busy8);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        start8 = 1'b1; op_a8 = 8'h35; op_b8 = 8'h4A;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ha_a8, ha_b8} !== 13'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ha=%b%b required all 0",
                     busy8, done8, sum8, cout8, ha_a8, ha_b8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start8 = 1'b1; op_a8 = 8'h80; op_b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL midrun_next_cycles: got %0d required 16", n);
        end
        n_checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL midrun_next_result: got done=%b cout=%b sum=%h required done=1 cout=1 sum=00",
                     done8, cout8, sum8);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        start8 = 1'b1; op_a8 = 8'h35; op_b8 = 8'h4A;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        n_checks++;
        if ({done8, sum8} !== {1'b1, 8'h7F}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b sum=%h required done=1 sum=7f", done8, sum8);
        end
        start8 = 1'b1; op_a8 = 8'h12; op_b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if ({busy8, done8, sum8} !== {1'b1, 1'b0, 8'h7F}) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b sum=%h required busy=1 done=0 sum=7f",
                     busy8, done8, sum8);
        end
        wait_done8(n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL b2b_busy_cycles: got %0d required 16", n);
        end
        n_checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h46}) begin
            n_fail++;
            $display("FAIL b2b_result: got done=%b cout=%b sum=%h required done=1 cout=0 sum=46",
                     done8, cout8, sum8);
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        int n;
        logic a, b;
        for (int i = 0; i < 4; i++) begin
            a = (i >= 2);
            b = (i % 2) == 1;
            start1 = 1'b1; op_a1 = a; op_b1 = b;
            @(negedge clk);
            start1 = 1'b0;
            wait_done1(n);
            n_checks++;
            if (n !== 2) begin
                n_fail++;
                $display("FAIL w1_busy_cycles_%0d: got %0d required 2", i, n);
            end
            n_checks++;
            if ({done1, cout1, sum1} !== {1'b1, a & b, a ^ b}) begin
                n_fail++;
                $display("FAIL w1_result_%0d: got done=%b cout=%b sum=%b required done=1 cout=%b sum=%b",
                         i, done1, cout1, sum1, a & b, a ^ b);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; op_a8 = 8'h00; op_b8 = 8'h00;
        start1 = 1'b0; op_a1 = 1'b0;  op_b1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ripple();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
